// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter (TXDATA/STATUS/BAUDDIV) with a small transmit FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame.
module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen,
  input  logic        ren,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] ADDR_TXDATA  = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_BAUDDIV = 8'h08;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
  localparam logic PARITY_EN = 1'b1;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
  localparam logic PARITY_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;
  logic          tx_q, tx_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   status;
  logic [15:0]   reload;
  logic          push_req, push, pop, fifo_full, fifo_empty, bit_end;
  logic          unused_wdata;

  assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign push_req     = wen && (addr == ADDR_TXDATA);
  assign push         = push_req && !fifo_full;
  assign bit_end      = (timer_q == '0);
  // A divisor of 0 behaves like 1, so both reload the timer with 0.
  assign reload       = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign unused_wdata = ^wdata[31:16];

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    if (state_q != S_IDLE && !bit_end) timer_d = timer_q - 16'd1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          state_d = S_START;
          timer_d = reload;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          timer_d   = reload;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = reload;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^shift_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          timer_d = reload;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit so queued bytes leave no idle gap.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = S_START;
            timer_d = reload;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    ovf_d = ovf_q;
    if (wen && addr == ADDR_STATUS) ovf_d = 1'b0;
    if (push_req && fifo_full) ovf_d = 1'b1;

    div_d = div_q;
    if (wen && addr == ADDR_BAUDDIV) div_d = wdata[15:0];

    status      = '0;
    status[0]   = (state_q != S_IDLE);
    status[1]   = fifo_full;
    status[2]   = fifo_empty;
    status[3]   = ovf_q;
    status[7:4] = 4'(count_q);
    status[8]   = PARITY_EN;

    rdata_d = '0;
    case (addr)
      ADDR_STATUS:  rdata_d = status;
      ADDR_BAUDDIV: rdata_d = {16'd0, div_q};
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      timer_q   <= '0;
      div_q     <= 16'(DEFAULT_DIV);
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (ren) rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  assign rdata = rdata_q;
  assign tx    = tx_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: written bytes go to a scoreboard queue and are
// popped and compared bit by bit (with per-bit duration) as frames appear on tx.
module tb_mmio_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam logic [31:0] PBIT = PAR ? 32'h100 : 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  mmio_uart_tx #(.FIFO_DEPTH(4), .DEFAULT_DIV(16)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren),
    .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    wen = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    ren = 1'b1; addr = a;
    @(negedge clk);
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sb_q.push_back(b);
    bus_write(8'h00, {24'd0, b});
  endtask

  // Entered on the first cycle of the start bit; returns on the first cycle after the stop bit.
  task automatic rx_frame(input int d_first, input int d_rest, input string name);
    logic [7:0]  exp;
    logic [10:0] bits;
    logic        bad, seen;
    int          nb, d;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: frame on tx with empty scoreboard", name);
      return;
    end
    exp = sb_q.pop_front();
    nb = PAR ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = exp;
    if (PAR) bits[9] = ^exp;
    for (int b = 0; b < nb; b++) begin
      d = (b == 0) ? d_first : d_rest;
      bad = 1'b0; seen = bits[b];
      for (int c = 0; c < d; c++) begin
        if (tx !== bits[b]) begin bad = 1'b1; seen = tx; end
        @(negedge clk);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit%0d of 0x%02h: tx=%b expected %b", name, b, exp, seen, bits[b]);
      end
    end
    $display("frame %s: byte 0x%02h checked", name, exp);
  endtask

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL %s: no start bit within %0d cycles, tx=%b expected 0", name, budget, tx); end
  endtask

  task automatic idle_check(input string name, input int cycles);
    logic bad = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (tx !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL %s: tx left idle, expected 1 for %0d cycles", name, cycles); end
  endtask

  task automatic check_read(input logic [7:0] a, input logic [31:0] exp, input string name);
    logic [31:0] r;
    bus_read(a, r);
    checks++;
    if (r !== exp) begin errors++; $display("FAIL %s: rdata=0x%08h expected 0x%08h", name, r, exp); end
    else $display("read %s: 0x%08h", name, r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: rdata=0x%08h expected 0", rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    check_read(8'h04, 32'h4 | PBIT, "reset_status");
    check_read(8'h08, 32'h10, "reset_bauddiv");
    check_read(8'h0C, 32'h0, "unmapped_offset");
  endtask

  task automatic test_frame();
    bus_write(8'h08, 32'd4);
    send_byte(8'hA5);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL latency_n1: tx=%b expected 1", tx); end
    @(negedge clk);
    rx_frame(4, 4, "a5_div4");
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL after_frame_tx: tx=%b expected 1", tx); end
    check_read(8'h04, 32'h4 | PBIT, "after_frame_status");
    check_read(8'h00, 32'h0, "txdata_reads_zero");
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [5];
    logic [31:0] r;
    bytes = '{8'h11, 8'h80, 8'hFF, 8'h5A, 8'hC3};
    bus_write(8'h08, 32'd2);
    fork
      begin
        wait_start("b2b_start", 20);
        for (int i = 0; i < 5; i++) rx_frame(2, 2, "b2b");
      end
      begin
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        bus_write(8'h00, 32'hEE);
        bus_read(8'h04, r);
        checks++;
        if (r !== (32'h4B | PBIT)) begin errors++; $display("FAIL full_overflow_status: rdata=0x%08h expected 0x%08h", r, 32'h4B | PBIT); end
      end
    join
    idle_check("b2b_no_extra", 30);
    check_read(8'h04, 32'h0C | PBIT, "overflow_sticky");
    bus_write(8'h04, 32'h0);
    check_read(8'h04, 32'h04 | PBIT, "overflow_cleared");
  endtask

  task automatic test_div_zero();
    bus_write(8'h08, 32'd0);
    check_read(8'h08, 32'h0, "bauddiv_zero");
    send_byte(8'h3C);
    @(negedge clk);
    rx_frame(1, 1, "div0");
    idle_check("div0_idle", 5);
  endtask

  task automatic test_div_change();
    bus_write(8'h08, 32'd2);
    send_byte(8'h96);
    @(negedge clk);
    fork
      rx_frame(2, 6, "div_change");
      bus_write(8'h08, 32'd6);
    join
    check_read(8'h08, 32'h6, "bauddiv_six");
  endtask

  task automatic test_reset_mid_frame();
    bus_write(8'h08, 32'd4);
    check_read(8'h08, 32'h4, "pre_reset_div");
    send_byte(8'h00);
    send_byte(8'h55);
    repeat (12) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_data: tx=%b expected 0", tx); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: tx=%b expected 1", tx); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL async_reset_rdata: rdata=0x%08h expected 0", rdata); end
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_read(8'h04, 32'h4 | PBIT, "post_reset_status");
    check_read(8'h08, 32'h10, "post_reset_div");
    idle_check("post_reset_idle", 60);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bus_write(8'h08, 32'd3);
    send_byte(8'h07);
    @(negedge clk);
    rx_frame(3, 3, "parity_07");
    check_read(8'h04, 32'h104, "parity_status");
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_div_zero();
    test_div_change();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drained: %0d left expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
